// File: rtl/song_selector_pkg.sv
// Shared definitions for the front-panel song selector.
//   - song bus codes (valid bit + one-hot index) and the cursor home position
//   - selector FSM state encoding
//   - resolved single-cycle button event payload
package song_selector_pkg;

    localparam int unsigned SONG_W = 5;
    localparam int unsigned CUR_W  = 4;

    localparam logic [SONG_W-1:0] SONG_NONE = 5'b00000;
    localparam logic [SONG_W-1:0] SONG1     = 5'b10001;
    localparam logic [SONG_W-1:0] SONG2     = 5'b10010;
    localparam logic [SONG_W-1:0] SONG3     = 5'b10100;
    localparam logic [SONG_W-1:0] SONG4     = 5'b11000;

    localparam logic [CUR_W-1:0] CURSOR_HOME = 4'b0001;

    typedef enum logic [1:0] {
        SEL_IDLE   = 2'd0,
        SEL_BROWSE = 2'd1,
        SEL_LOCKED = 2'd2
    } sel_state_e;

    // At most one field is set after priority resolution.
    typedef struct packed {
        logic back;
        logic ok;
        logic next;
        logic prev;
    } btn_evt_t;

    function automatic logic [CUR_W-1:0] rot_left(input logic [CUR_W-1:0] c);
        return {c[CUR_W-2:0], c[CUR_W-1]};
    endfunction

    function automatic logic [CUR_W-1:0] rot_right(input logic [CUR_W-1:0] c);
        return {c[0], c[CUR_W-1:1]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes, debounces and rising-edge-detects one raw push-button.
//   clk, rst_n : clock, async active-low reset
//   btn_raw    : raw asynchronous bouncing input
//   level      : debounced button level
//   press      : one-cycle pulse, registered one cycle after level rises
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned         CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Stability counter: a level change needs DB_CYCLES disagreeing samples in a row.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = level_q & ~level_dly_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/song_selector.sv
// Front-panel song selector: four debounced buttons drive a browse cursor
// and latch the chosen song onto the song bus.
//   clk, rst_n                         : clock, async active-low reset
//   btn_next/btn_prev/btn_ok/btn_back  : raw push-buttons
//   song      : {valid, one-hot index}, 0 when nothing selected
//   cursor    : one-hot browse position
//   song_load : one-cycle pulse when song takes a new nonzero code
module song_selector
    import song_selector_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_ok,
    input  logic              btn_back,
    output logic [SONG_W-1:0] song,
    output logic [CUR_W-1:0]  cursor,
    output logic              song_load
);

    logic     [3:0]        lvl_unused;
    btn_evt_t              press;
    btn_evt_t              evt;

    sel_state_e            state_q, state_d;
    logic     [SONG_W-1:0] song_q, song_d;
    logic     [CUR_W-1:0]  cursor_q, cursor_d;
    logic                  song_load_q, song_load_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_back (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_back), .level(lvl_unused[3]), .press(press.back));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ok (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_ok),   .level(lvl_unused[2]), .press(press.ok));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_next), .level(lvl_unused[1]), .press(press.next));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_prev), .level(lvl_unused[0]), .press(press.prev));

    // Same-cycle presses: back > ok > next > prev, losers are dropped.
    always_comb begin
        evt = '0;
        if (press.back)      evt.back = 1'b1;
        else if (press.ok)   evt.ok   = 1'b1;
        else if (press.next) evt.next = 1'b1;
        else if (press.prev) evt.prev = 1'b1;
    end

    // Selector FSM next state and registered-output values.
    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        cursor_d    = cursor_q;
        song_load_d = 1'b0;
        unique case (state_q)
            SEL_IDLE: begin
                if (evt.next || evt.prev) state_d = SEL_BROWSE;
            end
            SEL_BROWSE: begin
                if (evt.back) begin
                    state_d  = SEL_IDLE;
                    cursor_d = CURSOR_HOME;
                end else if (evt.ok) begin
                    state_d     = SEL_LOCKED;
                    song_d      = {1'b1, cursor_q};
                    song_load_d = 1'b1;
                end else if (evt.next) begin
                    cursor_d = rot_left(cursor_q);
                end else if (evt.prev) begin
                    cursor_d = rot_right(cursor_q);
                end
            end
            SEL_LOCKED: begin
                if (evt.back) begin
                    state_d = SEL_BROWSE;
                    song_d  = SONG_NONE;
                end
            end
            default: begin
                state_d  = SEL_IDLE;
                song_d   = SONG_NONE;
                cursor_d = CURSOR_HOME;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEL_IDLE;
            song_q      <= SONG_NONE;
            cursor_q    <= CURSOR_HOME;
            song_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_q      <= song_d;
            cursor_q    <= cursor_d;
            song_load_q <= song_load_d;
        end
    end

    assign song      = song_q;
    assign cursor    = cursor_q;
    assign song_load = song_load_q;

endmodule
